// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC scalar-multiplication controller:
// command encodings, sequencer states and default widths.
package ecc_pkg;

  localparam int KW_DEF = 4;
  localparam int W_DEF  = 4;

  localparam logic OP_DBL = 1'b0;
  localparam logic OP_ADD = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_DBL,
    S_DBL_W,
    S_ADD,
    S_ADD_W,
    S_FIN
  } state_t;

endpackage

// File: rtl/ecc_k_msb_find.sv
// Combinational priority encoder: index of the highest set bit of k,
// with a valid flag that is low when k is zero.
module ecc_k_msb_find #(
  parameter int KW = 4,
  parameter int BW = (KW > 1) ? $clog2(KW) : 1
) (
  input  logic [KW-1:0] k,
  output logic          valid,
  output logic [BW-1:0] msb
);

  // NOTE: both outputs get a default before the loop so no latch is inferred.
  always_comb begin
    valid = 1'b0;
    msb   = '0;
    for (int i = 0; i < KW; i++) begin
      if (k[i]) begin
        valid = 1'b1;
        msb   = BW'(i);
      end
    end
  end

endmodule

// File: rtl/ecc_scalar_mult_ctrl.sv
// Double-and-add sequencer for kP: scans k MSB-first, issues double/add
// commands to a shared point ALU over req/ack, tracks infinity locally.
module ecc_scalar_mult_ctrl
  import ecc_pkg::*;
#(
  parameter int KW = KW_DEF,
  parameter int W  = W_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [KW-1:0] k,
  input  logic [W-1:0]  Px,
  input  logic [W-1:0]  Py,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_inf,
  output logic [W-1:0]  kPx,
  output logic [W-1:0]  kPy,
  output logic          op_req,
  output logic          op_sel,
  output logic [W-1:0]  op_x1,
  output logic [W-1:0]  op_y1,
  output logic [W-1:0]  op_x2,
  output logic [W-1:0]  op_y2,
  input  logic          op_ack,
  input  logic [W-1:0]  op_rx,
  input  logic [W-1:0]  op_ry,
  input  logic          op_rinf
);

  localparam int BW = (KW > 1) ? $clog2(KW) : 1;

  state_t          state;
  logic [KW-1:0]   k_r;
  logic [W-1:0]    px_r, py_r;
  logic [W-1:0]    qx, qy;
  logic            qinf;
  logic [BW-1:0]   bit_idx;
  logic [BW-1:0]   msb;
  logic            msb_valid;
  state_t          step_state;

  ecc_k_msb_find #(.KW(KW), .BW(BW)) u_msb (
    .k     (k_r),
    .valid (msb_valid),
    .msb   (msb)
  );

  // Shared "bit step": finish after bit 0, otherwise double for the next bit.
  assign step_state = (bit_idx == '0) ? S_FIN : S_DBL;

  // The ALU's second operand is always the latched base point.
  assign op_x2 = px_r;
  assign op_y2 = py_r;

  // NOTE: sequential state uses non-blocking assignments only, and the async
  // reset drops op_req immediately when i_rst rises mid-operation.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= S_IDLE;
      k_r     <= '0;
      px_r    <= '0;
      py_r    <= '0;
      qx      <= '0;
      qy      <= '0;
      qinf    <= 1'b0;
      bit_idx <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_inf   <= 1'b0;
      kPx     <= '0;
      kPy     <= '0;
      op_req  <= 1'b0;
      op_sel  <= OP_DBL;
      op_x1   <= '0;
      op_y1   <= '0;
    end else begin
      o_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (i_start) begin
            k_r    <= k;
            px_r   <= Px;
            py_r   <= Py;
            o_inf  <= 1'b0;
            kPx    <= '0;
            kPy    <= '0;
            o_busy <= 1'b1;
            state  <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (!msb_valid) begin
            qinf  <= 1'b1;
            qx    <= '0;
            qy    <= '0;
            state <= S_FIN;
          end else begin
            qinf    <= 1'b0;
            qx      <= px_r;
            qy      <= py_r;
            bit_idx <= msb - BW'(1);
            state   <= (msb == '0) ? S_FIN : S_DBL;
          end
        end
        S_DBL: begin
          if (qinf) begin
            bit_idx <= bit_idx - BW'(1);
            state   <= step_state;
          end else begin
            op_req <= 1'b1;
            op_sel <= OP_DBL;
            op_x1  <= qx;
            op_y1  <= qy;
            state  <= S_DBL_W;
          end
        end
        S_DBL_W: begin
          if (op_ack) begin
            qx     <= op_rx;
            qy     <= op_ry;
            qinf   <= op_rinf;
            op_req <= 1'b0;
            if (k_r[bit_idx]) begin
              state <= S_ADD;
            end else begin
              bit_idx <= bit_idx - BW'(1);
              state   <= step_state;
            end
          end
        end
        S_ADD: begin
          if (qinf) begin
            // inf + P = P: no ALU round trip needed.
            qx      <= px_r;
            qy      <= py_r;
            qinf    <= 1'b0;
            bit_idx <= bit_idx - BW'(1);
            state   <= step_state;
          end else begin
            op_req <= 1'b1;
            op_sel <= OP_ADD;
            op_x1  <= qx;
            op_y1  <= qy;
            state  <= S_ADD_W;
          end
        end
        S_ADD_W: begin
          if (op_ack) begin
            qx      <= op_rx;
            qy      <= op_ry;
            qinf    <= op_rinf;
            op_req  <= 1'b0;
            bit_idx <= bit_idx - BW'(1);
            state   <= step_state;
          end
        end
        S_FIN: begin
          kPx    <= qinf ? '0 : qx;
          kPy    <= qinf ? '0 : qy;
          o_inf  <= qinf;
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_scalar_mult_ctrl.sv
// Self-checking bench for ecc_scalar_mult_ctrl: table of scalar/point vectors
// against a stub point ALU, plus timing, ignored-start and reset sequences.
module tb_ecc_scalar_mult_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_start = 1'b0;
  logic [3:0] k = '0, Px = '0, Py = '0;
  logic       o_busy, o_done, o_inf;
  logic [3:0] kPx, kPy;
  logic       op_req, op_sel;
  logic [3:0] op_x1, op_y1, op_x2, op_y2;
  logic       op_ack = 1'b0;
  logic [3:0] op_rx = '0, op_ry = '0;
  logic       op_rinf = 1'b0;

  ecc_scalar_mult_ctrl #(.KW(4), .W(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start), .k(k), .Px(Px), .Py(Py),
    .o_busy(o_busy), .o_done(o_done), .o_inf(o_inf), .kPx(kPx), .kPy(kPy),
    .op_req(op_req), .op_sel(op_sel), .op_x1(op_x1), .op_y1(op_y1),
    .op_x2(op_x2), .op_y2(op_y2), .op_ack(op_ack), .op_rx(op_rx),
    .op_ry(op_ry), .op_rinf(op_rinf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Stub ALU: result of command i is (base_x+i, base_y+i), infinity per inf_mask[i].
  int         lat = 1;
  logic [3:0] base_x = '0, base_y = '0;
  logic [7:0] inf_mask = '0;
  logic [3:0] exp_px = '0, exp_py = '0;
  int         ncmd = 0, cnt = 0, add_bad = 0, b2b_viol = 0, done_cnt = 0;
  logic [15:0] seq = '0;
  logic [3:0] first_x1 = '0, first_y1 = '0;

  always @(negedge clk) begin
    if (o_done) done_cnt++;
    if (rst) begin
      op_ack = 1'b0;
      cnt = 0;
    end else if (op_ack) begin
      op_ack = 1'b0;
      if (op_req) b2b_viol++;
    end else if (op_req) begin
      cnt++;
      if (cnt >= lat) begin
        op_ack  = 1'b1;
        op_rx   = base_x + 4'(ncmd);
        op_ry   = base_y + 4'(ncmd);
        op_rinf = (ncmd < 8) ? inf_mask[ncmd] : 1'b0;
        if (ncmd < 16) seq[ncmd] = op_sel;
        if (ncmd == 0) begin
          first_x1 = op_x1;
          first_y1 = op_y1;
        end
        if (op_sel && (op_x2 != exp_px || op_y2 != exp_py)) add_bad++;
        ncmd++;
        cnt = 0;
      end
    end else begin
      cnt = 0;
    end
  end

  typedef struct {
    logic [3:0]  k, px, py;
    int          lat;
    logic [3:0]  bx, by;
    logic [7:0]  imask;
    int          ncmd;
    logic [15:0] seq;
    logic [3:0]  ex, ey;
    logic        einf;
  } vec_t;

  vec_t vecs[9];

  task automatic setup_job(input logic [3:0] vk, input logic [3:0] vx, input logic [3:0] vy,
                           input int vlat, input logic [3:0] bx, input logic [3:0] by,
                           input logic [7:0] im);
    lat = vlat; base_x = bx; base_y = by; inf_mask = im;
    exp_px = vx; exp_py = vy;
    ncmd = 0; seq = '0; add_bad = 0; b2b_viol = 0; done_cnt = 0;
    first_x1 = '0; first_y1 = '0;
    k = vk; Px = vx; Py = vy;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (done_cnt == 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check({name, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_result(input string name, input vec_t v);
    check({name, "_ncmd"}, 32'(ncmd), 32'(v.ncmd));
    check({name, "_seq"}, 32'(seq), 32'(v.seq));
    check({name, "_add_p"}, 32'(add_bad), 32'd0);
    check({name, "_b2b"}, 32'(b2b_viol), 32'd0);
    check({name, "_one_done"}, 32'(done_cnt), 32'd1);
    check({name, "_kPx"}, 32'(kPx), 32'(v.ex));
    check({name, "_kPy"}, 32'(kPy), 32'(v.ey));
    check({name, "_inf"}, 32'(o_inf), 32'(v.einf));
    check({name, "_idle"}, 32'(o_busy), 32'd0);
    if (v.ncmd > 0) check({name, "_first_q"}, {24'd0, first_x1, first_y1}, {24'd0, v.px, v.py});
  endtask

  initial begin
    vecs[0] = '{4'd0,  4'd3, 4'd6, 1, 4'd0,  4'd0, 8'h00, 0, 16'h0000, 4'd0,  4'd0,  1'b1};
    vecs[1] = '{4'd1,  4'd3, 4'd6, 1, 4'd0,  4'd0, 8'h00, 0, 16'h0000, 4'd3,  4'd6,  1'b0};
    vecs[2] = '{4'd5,  4'd3, 4'd6, 3, 4'd10, 4'd1, 8'h00, 3, 16'h0004, 4'd12, 4'd3,  1'b0};
    vecs[3] = '{4'd2,  4'd3, 4'd6, 2, 4'd5,  4'd5, 8'h01, 1, 16'h0000, 4'd0,  4'd0,  1'b1};
    vecs[4] = '{4'd3,  4'd3, 4'd6, 2, 4'd5,  4'd5, 8'h01, 1, 16'h0000, 4'd3,  4'd6,  1'b0};
    vecs[5] = '{4'd6,  4'd3, 4'd6, 1, 4'd7,  4'd8, 8'h00, 3, 16'h0002, 4'd9,  4'd10, 1'b0};
    vecs[6] = '{4'd15, 4'd5, 4'd9, 2, 4'd1,  4'd2, 8'h00, 6, 16'h002A, 4'd6,  4'd7,  1'b0};
    vecs[7] = '{4'd8,  4'd2, 4'd4, 1, 4'd9,  4'd9, 8'h01, 1, 16'h0000, 4'd0,  4'd0,  1'b1};
    vecs[8] = '{4'd12, 4'd1, 4'd1, 2, 4'd4,  4'd4, 8'h01, 3, 16'h0000, 4'd6,  4'd6,  1'b0};

    repeat (2) @(negedge clk);
    check("reset_req", 32'(op_req), 32'd0);
    check("reset_busy_done", {30'd0, o_busy, o_done}, 32'd0);
    check("reset_result", {23'd0, o_inf, kPx, kPy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      setup_job(vecs[i].k, vecs[i].px, vecs[i].py, vecs[i].lat, vecs[i].bx, vecs[i].by,
                vecs[i].imask);
      check($sformatf("v%0d_busy", i), 32'(o_busy), 32'd1);
      wait_done($sformatf("v%0d", i));
      check_result($sformatf("v%0d", i), vecs[i]);
    end

    // k=0 latency: start edge e0, done registered at e2, cleared at e3.
    setup_job(4'd0, 4'd3, 4'd6, 1, 4'd0, 4'd0, 8'h00);
    check("k0_t1_done", {30'd0, o_busy, o_done}, 32'b10);
    @(negedge clk);
    check("k0_t2_done", {30'd0, o_busy, o_done}, 32'b10);
    @(negedge clk);
    check("k0_t3_done", {29'd0, o_busy, o_done, o_inf}, 32'b011);
    @(negedge clk);
    check("k0_t4_done", 32'(o_done), 32'd0);
    check("k0_req_none", 32'(ncmd), 32'd0);

    // Start pulse with k=9 while waiting on the first double must be ignored.
    setup_job(4'd5, 4'd3, 4'd6, 3, 4'd10, 4'd1, 8'h00);
    begin
      int t = 0;
      while (!op_req && t < 50) begin @(negedge clk); t++; end
      check("ign_req_seen", 32'(op_req), 32'd1);
    end
    k = 4'd9; Px = 4'd1; Py = 4'd2; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_done("ign");
    repeat (6) @(negedge clk);
    check_result("ign", vecs[2]);

    // Reset while op_req is high: op_req falls without a clock edge.
    setup_job(4'd5, 4'd3, 4'd6, 5, 4'd10, 4'd1, 8'h00);
    begin
      int t = 0;
      while (!op_req && t < 50) begin @(negedge clk); t++; end
      check("rst_req_seen", 32'(op_req), 32'd1);
    end
    #2 rst = 1'b1;
    #1 check("rst_req_drop", 32'(op_req), 32'd0);
    check("rst_busy_drop", 32'(o_busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_no_done", 32'(done_cnt), 32'd0);
    setup_job(4'd5, 4'd3, 4'd6, 1, 4'd10, 4'd1, 8'h00);
    wait_done("rst_re");
    check_result("rst_re", vecs[2]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
